// File: rtl/spi_loader_pkg.sv
// rtl/spi_loader_pkg.sv - shared types and constants for the SPI frame-memory loader
package spi_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA,
    ST_DISCARD
  } state_t;

  localparam logic [7:0] DEF_CMD_WRITE    = 8'hF0;
  localparam logic [7:0] DEF_CMD_WRITE_AT = 8'hF1;
  localparam int         SYNC_DEPTH       = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - two-flop synchroniser plus history flop with edge detect
module spi_sync_edge
  import spi_loader_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync;
  logic                  hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_DEPTH{INIT}};
      hist <= INIT;
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], din};
      hist <= sync[SYNC_DEPTH-1];
    end
  end

  assign level = sync[SYNC_DEPTH-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_mem_loader.sv
// rtl/spi_mem_loader.sv - SPI slave command decoder driving sequential frame-memory byte writes
module spi_mem_loader
  import spi_loader_pkg::*;
#(
  parameter int         ADDR_W       = 9,
  parameter logic [7:0] CMD_WRITE    = DEF_CMD_WRITE,
  parameter logic [7:0] CMD_WRITE_AT = DEF_CMD_WRITE_AT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_ss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  output logic              frame_done,
  output logic              busy
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_end, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge #(.INIT(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .din(spi_sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.INIT(1'b1)) u_ss (
    .clk(clk), .rst(rst), .din(spi_ss), .level(ss_lvl), .rise(ss_end), .fall(ss_fall)
  );
  spi_sync_edge #(.INIT(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(spi_mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, sclk_lvl, ss_fall, mosi_rise, mosi_fall};

  state_t            state;
  logic [2:0]        cnt;
  logic [7:0]        shreg;
  logic [7:0]        tx;
  logic [7:0]        addr_hi;
  logic [ADDR_W-1:0] addr;
  logic              wrote;
  logic              frame_pend;

  logic [7:0] rx_byte;
  logic       bit_in;
  logic       byte_done;

  assign rx_byte   = {shreg[6:0], mosi_lvl};
  assign bit_in    = sclk_rise & ~ss_lvl;
  assign byte_done = bit_in & (cnt == 3'd7);
  assign spi_miso  = tx[7];
  assign busy      = ~ss_lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      tx          <= '0;
      addr_hi     <= '0;
      addr        <= '0;
      wrote       <= 1'b0;
      frame_pend  <= 1'b0;
      frame_done  <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_wr_en  <= 1'b0;
      frame_pend <= ss_end & (state == ST_DATA) & wrote;
      frame_done <= frame_pend;

      if (bit_in) begin
        shreg <= rx_byte;
        cnt   <= cnt + 3'd1;
      end
      // The fall right after a completed byte presents the new MSB, so it must not shift.
      if (sclk_fall && !ss_lvl && cnt != 3'd0)
        tx <= {tx[6:0], 1'b0};
      if (byte_done)
        tx <= rx_byte;

      if (ss_lvl) begin
        state <= ST_IDLE;
        cnt   <= '0;
        shreg <= '0;
        tx    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_CMD;
            wrote <= 1'b0;
          end
          ST_CMD: if (byte_done) begin
            if (rx_byte == CMD_WRITE) begin
              addr  <= '0;
              state <= ST_DATA;
            end else if (rx_byte == CMD_WRITE_AT) begin
              state <= ST_ADDR_HI;
            end else begin
              state <= ST_DISCARD;
            end
          end
          ST_ADDR_HI: if (byte_done) begin
            addr_hi <= rx_byte;
            state   <= ST_ADDR_LO;
          end
          ST_ADDR_LO: if (byte_done) begin
            addr  <= ADDR_W'({addr_hi, rx_byte});
            state <= ST_DATA;
          end
          ST_DATA: if (byte_done) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= addr;
            mem_wr_data <= rx_byte;
            addr        <= addr + ADDR_W'(1);
            wrote       <= 1'b1;
          end
          ST_DISCARD: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_loader.sv
// tb/tb_spi_mem_loader.sv - randomized self-checking bench for spi_mem_loader
module tb_spi_mem_loader;

  localparam int ADDR_W = 9;
  localparam int AMOD   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              spi_sclk = 1'b0;
  logic              spi_ss = 1'b1;
  logic              spi_mosi = 1'b0;
  logic              spi_miso;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [7:0]        mem_wr_data;
  logic              frame_done;
  logic              busy;

  spi_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int fd_cyc_q[$];
  logic [7:0] txq[$];

  initial forever begin
    @(posedge clk);
    #1;
    if (mem_wr_en) begin
      wr_addr_q.push_back(int'(mem_wr_addr));
      wr_data_q.push_back(int'(mem_wr_data));
      wr_cyc_q.push_back(cyc);
    end
    if (frame_done) fd_cyc_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    fd_cyc_q.delete();
  endtask

  // Called at a negedge; returns the miso bit seen just before the rise and the edge that samples sclk high.
  task automatic send_bit(input logic b, input int hi, input int lo, output logic ms, output int k);
    spi_mosi = b;
    repeat (lo) @(negedge clk);
    ms = spi_miso;
    spi_sclk = 1'b1;
    k = cyc + 1;
    repeat (hi) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  // Sends txq as one transaction; the final byte carries only last_bits bits when last_bits < 8.
  task automatic run_txn(input string name, input int last_bits, input int hi, input int lo);
    int kq[$];
    int exp_addr[$];
    int exp_data[$];
    int exp_cyc[$];
    int nfull, first, base, nb, k, ss_c;
    logic ms;
    logic [7:0] rxm;
    clear_obs();
    spi_ss = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < txq.size(); i++) begin
      nb = (i == txq.size() - 1 && last_bits < 8) ? last_bits : 8;
      rxm = 8'h00;
      for (int b = 0; b < nb; b++) begin
        send_bit(txq[i][7-b], hi, lo, ms, k);
        rxm[7-b] = ms;
      end
      if (nb == 8) begin
        kq.push_back(k);
        chk({name, "_miso"}, 32'(rxm), (i == 0) ? 32'h0 : 32'(txq[i-1]));
      end
    end
    repeat (4) @(negedge clk);
    spi_ss = 1'b1;
    ss_c = cyc + 1;
    repeat (10) @(negedge clk);

    nfull = (last_bits < 8) ? txq.size() - 1 : txq.size();
    first = -1;
    base  = 0;
    if (nfull >= 1 && txq[0] == 8'hF0) begin
      first = 1;
      base  = 0;
    end else if (nfull >= 3 && txq[0] == 8'hF1) begin
      first = 3;
      base  = (int'(txq[1]) * 256 + int'(txq[2])) % AMOD;
    end
    if (first > 0) begin
      for (int j = first; j < nfull; j++) begin
        exp_addr.push_back((base + j - first) % AMOD);
        exp_data.push_back(int'(txq[j]));
        exp_cyc.push_back(kq[j] + 2);
      end
    end

    chk({name, "_wr_count"}, 32'(wr_addr_q.size()), 32'(exp_addr.size()));
    for (int j = 0; j < exp_addr.size() && j < wr_addr_q.size(); j++) begin
      chk({name, "_wr_addr"}, 32'(wr_addr_q[j]), 32'(exp_addr[j]));
      chk({name, "_wr_data"}, 32'(wr_data_q[j]), 32'(exp_data[j]));
      chk({name, "_wr_latency"}, 32'(wr_cyc_q[j]), 32'(exp_cyc[j]));
    end
    chk({name, "_frame_count"}, 32'(fd_cyc_q.size()), (exp_addr.size() > 0) ? 32'd1 : 32'd0);
    if (exp_addr.size() > 0 && fd_cyc_q.size() > 0)
      chk({name, "_frame_time"}, 32'(fd_cyc_q[0]), 32'(ss_c + 3));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    chk({name, "_wr_addr"}, 32'(mem_wr_addr), 32'd0);
    chk({name, "_wr_data"}, 32'(mem_wr_data), 32'd0);
    chk({name, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_miso"}, 32'(spi_miso), 32'd0);
  endtask

  initial begin
    logic ms;
    int k, sel, ndat, lb;
    logic [7:0] cmd;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    txq = '{8'hF0, 8'hFF, 8'h00, 8'hFF};
    run_txn("basic", 8, 2, 4);

    txq = '{8'hF1, 8'h01, 8'hFE, 8'hAA, 8'hBB, 8'hCC};
    run_txn("wrap", 8, 2, 4);

    txq = '{8'hF0, 8'hB6};
    run_txn("abort", 5, 2, 4);
    txq = '{8'hF0, 8'h12, 8'h34};
    run_txn("after_abort", 8, 2, 4);

    txq = '{8'h3C, 8'h11, 8'h22};
    run_txn("discard", 8, 2, 4);

    // Reset in the middle of the second data byte, then the rest of that byte.
    clear_obs();
    txq = '{8'hF0, 8'hA5, 8'h5A};
    spi_ss = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 8; b++) send_bit(txq[i][7-b], 2, 4, ms, k);
    for (int b = 0; b < 4; b++) send_bit(txq[2][7-b], 2, 4, ms, k);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int b = 4; b < 8; b++) send_bit(txq[2][7-b], 2, 4, ms, k);
    repeat (4) @(negedge clk);
    spi_ss = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_wr_count", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() > 0) chk("midrst_first_data", 32'(wr_data_q[0]), 32'hA5);
    chk("midrst_frame_count", 32'(fd_cyc_q.size()), 32'd0);

    txq = '{8'hF1, 8'h00, 8'h10, 8'h5A, 8'hC3, 8'h7E};
    run_txn("minwidth", 8, 1, 3);

    for (int r = 0; r < 20; r++) begin
      sel = $urandom_range(0, 3);
      cmd = 8'($urandom_range(0, 255));
      txq.delete();
      if (sel <= 1) txq.push_back(8'hF0);
      else if (sel == 2) begin
        txq.push_back(8'hF1);
        txq.push_back(8'($urandom_range(0, 255)));
        txq.push_back(8'($urandom_range(0, 255)));
      end else txq.push_back(cmd);
      ndat = $urandom_range(0, 5);
      for (int j = 0; j < ndat; j++) txq.push_back(8'($urandom_range(0, 255)));
      lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
      run_txn("rand", lb, $urandom_range(1, 3), $urandom_range(3, 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_mem_loader.md
# spi_mem_loader

- Receives the display-controller SPI stream in the system clock domain and turns it into byte writes on the frame memory's write port.
- Sits between the top-level `spi_*` pins and the display memory.
- Synchronises and edge-detects the slave-side SPI signals, decodes a command byte, and drives sequential memory writes.
- Pulses `frame_done` when a write transaction ends, so the scanout logic can latch a complete frame.

## Interface

Parameters:
- `ADDR_W`, default 9: memory address width; addresses wrap modulo 2^ADDR_W.
- `CMD_WRITE`, default 8'hF0: write from address 0.
- `CMD_WRITE_AT`, default 8'hF1: write from an explicit address.

Ports (all synchronous to `clk`; reset is synchronous and active-high):
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `spi_sclk`  in  1: SPI clock, asynchronous to `clk`, mode 0.
- `spi_ss`  in  1: slave select, active-low, asynchronous.
- `spi_mosi`  in  1: serial data in, MSB first, asynchronous.
- `spi_miso`  out  1: serial data out.
- `mem_wr_en`  out  1: one-cycle write strobe.
- `mem_wr_addr`  out  ADDR_W: write address.
- `mem_wr_data`  out  8: write data.
- `frame_done`  out  1: one-cycle pulse at the end of a write transaction.
- `busy`  out  1: high while synchronised `ss` is low.

## Operation

Input conditioning:
- `spi_sclk`, `spi_ss` and `spi_mosi` each pass through a 2-flop synchroniser, then one history flop.
- `rise` = synchronised sclk high and history low.
- `fall` = synchronised sclk low and history high.
- `ss_end` = synchronised ss high and history low.

Bit assembly:
- On each `rise` while ss is low, shift synchronised mosi into an 8-bit shift register and increment a 3-bit counter.
- The byte is complete when the counter wraps 7→0.

FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, DATA, DISCARD.
- IDLE → CMD when synchronised ss goes low.
- CMD, on byte complete:
  - `CMD_WRITE` → DATA with address 0.
  - `CMD_WRITE_AT` → ADDR_HI.
  - Any other value → DISCARD.
- ADDR_HI: the byte supplies address bits above 8, masked to ADDR_W. Go to ADDR_LO.
- ADDR_LO: the byte supplies the low 8 bits. Go to DATA.
- DATA: each complete byte produces a write at the current address, then the address increments, wrapping 2^ADDR_W−1 → 0.
- DISCARD: ignore all bytes.
- Any state → IDLE when synchronised ss is high. This clears the counter and drops any partial byte; no write is issued for it.

`frame_done`:
- Pulses on `ss_end` only if the transaction was in DATA and issued at least one write.
- Aborted transactions (fewer than 8 bits, or ending in CMD/ADDR) give no pulse.

`spi_miso`:
- Returns the previous received byte, MSB first.
- The transmit register loads on byte complete.
- It shifts on `fall`.
- It reads 8'h00 during the first byte of a transaction.

## Timing

Reset values:
- `mem_wr_en` = 0, `mem_wr_addr` = 0, `mem_wr_data` = 0.
- `frame_done` = 0, `busy` = 0, `spi_miso` = 0.
- FSM in IDLE, counter = 0, synchroniser flops = 1 for ss and 0 for the others.
- `rst` asserted mid-transaction aborts it with no write and no `frame_done`.

Write latency:
- Let edge k be the first `clk` edge that samples the 8th `spi_sclk` high.
- `mem_wr_en`, `mem_wr_addr` and `mem_wr_data` are registered at edge k+2.
- All three are valid for exactly one cycle.
- `mem_wr_addr`/`mem_wr_data` hold their values after the strobe.

`frame_done`: registered 3 edges after the first edge that samples `spi_ss` high.

Input requirements:
- `spi_sclk` high and low phases must each span at least one rising `clk` edge.
- `spi_mosi` must be stable from one `clk` period before the sclk rise through the first edge that samples it high.
- Byte throughput is therefore at most one byte per 16 `clk` cycles.
- `busy` follows synchronised ss with 2-cycle latency.

## Structure

Package `spi_loader_pkg` holds:
- the state enum,
- `CMD_WRITE`/`CMD_WRITE_AT` default constants,
- the sync depth constant (2).

Sub-module `spi_sync_edge`: one instance per input. It holds the 2-flop synchroniser plus history flop and outputs level, `rise` and `fall`. The FSM and datapath stay in `spi_mem_loader`.

## Test plan

- Reset, then ss low; send F0 FF 00 FF; ss high → writes (0,FF), (1,00), (2,FF); `frame_done` pulses once, 3 cycles after ss is sampled high.
- Send F1 01 FE AA BB CC with ADDR_W=9 → writes (0x1FE,AA), (0x1FF,BB), (0x000,CC), showing address wrap.
- Send F0 then 5 bits of a byte; ss high → no write; `frame_done` is 0; the next transaction starts cleanly at address 0.
- Send 3C 11 22 → no writes and no `frame_done`; `spi_miso` returns 00, 3C, 11 across the three bytes.
- Assert `rst` during the second data byte of an F0 stream → outputs return to reset values next cycle; no further writes.
- Drive minimum-width sclk (one `clk` edge high, three low) → byte capture is exact; `mem_wr_en` rises exactly 2 edges after the 8th high sample.
